// File: rtl/lsu_mmio.sv
// Load/store unit with data memory and memory-mapped LED/HEX outputs and synchronized switch/button inputs.
// Loads are combinational; stores, output registers and synchronizers update on the rising clock edge.
module lsu_mmio #(
   parameter int unsigned DMEM_WORDS = 2048
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   input  logic [2:0]  lsu_op_i,
   input  logic        lsu_wr_en_i,
   input  logic        lsu_rd_en_i,
   input  logic [31:0] sw_i,
   input  logic [3:0]  btn_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] ledr_o,
   output logic [31:0] ledg_o,
   output logic [31:0] hex_lo_o,
   output logic [31:0] hex_hi_o
);

   localparam int unsigned AW = $clog2(DMEM_WORDS);

   localparam logic [13:0] WA_LEDR   = 14'(16'h7000 >> 2);
   localparam logic [13:0] WA_LEDG   = 14'(16'h7010 >> 2);
   localparam logic [13:0] WA_HEX_LO = 14'(16'h7020 >> 2);
   localparam logic [13:0] WA_HEX_HI = 14'(16'h7024 >> 2);
   localparam logic [13:0] WA_SW     = 14'(16'h7800 >> 2);
   localparam logic [13:0] WA_BTN    = 14'(16'h7810 >> 2);

   logic [31:0] dmem_q [DMEM_WORDS];

   logic [31:0] ledr_q, ledr_d;
   logic [31:0] ledg_q, ledg_d;
   logic [31:0] hex_lo_q, hex_lo_d;
   logic [31:0] hex_hi_q, hex_hi_d;
   logic [31:0] sw_s1_q, sw_s2_q;
   logic [3:0]  btn_s1_q, btn_s2_q;

   logic [13:0]   word_addr;
   logic [1:0]    byte_off;
   logic [AW-1:0] dmem_idx;
   logic          sel_dmem;
   logic [3:0]    be;
   logic [31:0]   wd_lane;
   logic [31:0]   src_word;
   logic [31:0]   byte_shift;
   logic [31:0]   half_shift;
   logic          unused_addr;

   assign word_addr   = lsu_addr_i[15:2];
   assign byte_off    = lsu_addr_i[1:0];
   assign dmem_idx    = lsu_addr_i[AW+1:2];
   assign sel_dmem    = (lsu_addr_i[15:13] == 3'b001);
   assign unused_addr = ^lsu_addr_i[31:16];

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] en);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (en[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

   // Byte enables and replicated store data; the address is force-aligned, never faulted.
   always_comb begin
      be      = 4'b0000;
      wd_lane = lsu_wdata_i;
      if (lsu_wr_en_i) begin
         case (lsu_op_i)
            3'd0: begin
               be      = 4'b0001 << byte_off;
               wd_lane = {4{lsu_wdata_i[7:0]}};
            end
            3'd1: begin
               be      = byte_off[1] ? 4'b1100 : 4'b0011;
               wd_lane = {2{lsu_wdata_i[15:0]}};
            end
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
         endcase
      end
   end

   always_comb begin
      ledr_d   = ledr_q;
      ledg_d   = ledg_q;
      hex_lo_d = hex_lo_q;
      hex_hi_d = hex_hi_q;
      if (!sel_dmem) begin
         if (word_addr == WA_LEDR)   ledr_d   = merge(ledr_q, wd_lane, be);
         if (word_addr == WA_LEDG)   ledg_d   = merge(ledg_q, wd_lane, be);
         if (word_addr == WA_HEX_LO) hex_lo_d = merge(hex_lo_q, wd_lane, be);
         if (word_addr == WA_HEX_HI) hex_hi_d = merge(hex_hi_q, wd_lane, be);
      end
   end

   // DMEM has no reset, so a store issued during reset still lands.
   always_ff @(posedge clk_i) begin
      if (sel_dmem) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) dmem_q[dmem_idx][8*b +: 8] <= wd_lane[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ledr_q   <= '0;
         ledg_q   <= '0;
         hex_lo_q <= '0;
         hex_hi_q <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         btn_s1_q <= '0;
         btn_s2_q <= '0;
      end else begin
         ledr_q   <= ledr_d;
         ledg_q   <= ledg_d;
         hex_lo_q <= hex_lo_d;
         hex_hi_q <= hex_hi_d;
         sw_s1_q  <= sw_i;
         sw_s2_q  <= sw_s1_q;
         btn_s1_q <= btn_i;
         btn_s2_q <= btn_s1_q;
      end
   end

   always_comb begin
      src_word = '0;
      if (sel_dmem) begin
         src_word = dmem_q[dmem_idx];
      end else begin
         case (word_addr)
            WA_LEDR:   src_word = ledr_q;
            WA_LEDG:   src_word = ledg_q;
            WA_HEX_LO: src_word = hex_lo_q;
            WA_HEX_HI: src_word = hex_hi_q;
            WA_SW:     src_word = sw_s2_q;
            WA_BTN:    src_word = {28'd0, btn_s2_q};
            default:   src_word = '0;
         endcase
      end
   end

   assign byte_shift = src_word >> {byte_off, 3'b000};
   assign half_shift = src_word >> {byte_off[1], 4'b0000};

   always_comb begin
      ld_data_o = '0;
      if (lsu_rd_en_i) begin
         case (lsu_op_i)
            3'd0:    ld_data_o = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'd1:    ld_data_o = {{16{half_shift[15]}}, half_shift[15:0]};
            3'd2:    ld_data_o = src_word;
            3'd4:    ld_data_o = {24'd0, byte_shift[7:0]};
            3'd5:    ld_data_o = {16'd0, half_shift[15:0]};
            default: ld_data_o = '0;
         endcase
      end
   end

   assign ledr_o   = ledr_q;
   assign ledg_o   = ledg_q;
   assign hex_lo_o = hex_lo_q;
   assign hex_hi_o = hex_hi_q;

endmodule

// File: tb/tb_lsu_mmio.sv
// Scoreboard bench for lsu_mmio: stimulus pushes hand-computed expectations, a monitor on the
// falling edge pops and compares them against the selected DUT output.
module tb_lsu_mmio;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic [2:0]  lsu_op_i;
   logic        lsu_wr_en_i;
   logic        lsu_rd_en_i;
   logic [31:0] sw_i;
   logic [3:0]  btn_i;
   logic [31:0] ld_data_o;
   logic [31:0] ledr_o;
   logic [31:0] ledg_o;
   logic [31:0] hex_lo_o;
   logic [31:0] hex_hi_o;

   lsu_mmio #(.DMEM_WORDS(2048)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_op_i(lsu_op_i),
      .lsu_wr_en_i(lsu_wr_en_i), .lsu_rd_en_i(lsu_rd_en_i),
      .sw_i(sw_i), .btn_i(btn_i),
      .ld_data_o(ld_data_o), .ledr_o(ledr_o), .ledg_o(ledg_o),
      .hex_lo_o(hex_lo_o), .hex_hi_o(hex_hi_o)
   );

   always #5 clk_i = ~clk_i;

   localparam int K_LD = 0, K_LEDR = 1, K_LEDG = 2, K_HLO = 3, K_HHI = 4;

   typedef struct {
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   // Monitor: outputs are stable mid-cycle, so every pending expectation is checked here.
   always @(negedge clk_i) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = sb.pop_front();
         case (e.kind)
            K_LD:    act = ld_data_o;
            K_LEDR:  act = ledr_o;
            K_LEDG:  act = ledg_o;
            K_HLO:   act = hex_lo_o;
            default: act = hex_hi_o;
         endcase
         n_vec++;
         if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
         end
      end
   end

   task automatic push(input int kind, input string name, input logic [31:0] val);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic acc(input logic we, input logic re, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] wd);
      lsu_wr_en_i = we;
      lsu_rd_en_i = re;
      lsu_op_i    = op;
      lsu_addr_i  = a;
      lsu_wdata_i = wd;
   endtask

   task automatic ld(input logic [2:0] op, input logic [31:0] a, input string name,
                     input logic [31:0] val);
      acc(1'b0, 1'b1, op, a, 32'h0);
      push(K_LD, name, val);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      lsu_wr_en_i = 1'b0;
      lsu_rd_en_i = 1'b0;
   endtask

   task automatic st(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
      acc(1'b1, 1'b0, op, a, wd);
      tick();
   endtask

   initial begin
      rst_i = 1'b1;
      sw_i  = 32'h0;
      btn_i = 4'h0;
      acc(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      tick();
      tick();
      rst_i = 1'b0;
      push(K_LEDR, "rst_ledr", 32'h0);
      push(K_LEDG, "rst_ledg", 32'h0);
      push(K_HLO, "rst_hex_lo", 32'h0);
      push(K_HHI, "rst_hex_hi", 32'h0);
      ld(3'd2, 32'h0000_7800, "rst_sw_sync", 32'h0);
      tick();

      // word store / same-cycle old data / next-cycle new data
      st(3'd2, 32'h0000_2004, 32'h1111_1111);
      acc(1'b1, 1'b1, 3'd2, 32'h0000_2004, 32'hDEAD_BEEF);
      push(K_LD, "sw_same_cycle_old", 32'h1111_1111);
      tick();
      ld(3'd2, 32'h0000_2004, "lw_2004", 32'hDEAD_BEEF); tick();

      // byte/half extension and forced alignment
      ld(3'd0, 32'h0000_2007, "lb_2007", 32'hFFFF_FFDE); tick();
      ld(3'd4, 32'h0000_2007, "lbu_2007", 32'h0000_00DE); tick();
      ld(3'd0, 32'h0000_2004, "lb_2004", 32'hFFFF_FFEF); tick();
      ld(3'd4, 32'h0000_2005, "lbu_2005", 32'h0000_00BE); tick();
      ld(3'd1, 32'h0000_2004, "lh_2004", 32'hFFFF_BEEF); tick();
      ld(3'd5, 32'h0000_2006, "lhu_2006", 32'h0000_DEAD); tick();
      ld(3'd1, 32'h0000_2007, "lh_2007_align", 32'hFFFF_DEAD); tick();
      ld(3'd2, 32'h0000_2006, "lw_2006_align", 32'hDEAD_BEEF); tick();

      // partial stores use only the low byte/half of wdata
      st(3'd0, 32'h0000_2005, 32'hAAAA_AA55);
      st(3'd1, 32'h0000_2006, 32'hFFFF_1234);
      ld(3'd2, 32'h0000_2004, "lw_after_partial", 32'h1234_55EF); tick();
      ld(3'd2, 32'h1234_2004, "lw_upper_addr_ignored", 32'h1234_55EF); tick();

      // output registers
      st(3'd2, 32'h0000_7000, 32'h0000_00FF);
      push(K_LEDR, "ledr_ff", 32'h0000_00FF);
      ld(3'd2, 32'h0000_7000, "lw_ledr", 32'h0000_00FF); tick();
      st(3'd0, 32'h0000_7022, 32'h0000_003F);
      push(K_HLO, "hex_lo_sb", 32'h003F_0000); tick();
      st(3'd2, 32'h0000_7010, 32'h1234_5678);
      st(3'd1, 32'h0000_7026, 32'h0000_ABCD);
      push(K_LEDG, "ledg_sw", 32'h1234_5678);
      push(K_HHI, "hex_hi_sh", 32'hABCD_0000);
      ld(3'd5, 32'h0000_7012, "lhu_ledg_hi", 32'h0000_1234); tick();

      // reset beats an output store; a DMEM store during reset still lands
      rst_i = 1'b1;
      st(3'd2, 32'h0000_7000, 32'h0000_0077);
      st(3'd2, 32'h0000_2008, 32'hCAFE_F00D);
      rst_i = 1'b0;
      push(K_LEDR, "ledr_after_rst", 32'h0);
      push(K_LEDG, "ledg_after_rst", 32'h0);
      push(K_HLO, "hex_lo_after_rst", 32'h0);
      push(K_HHI, "hex_hi_after_rst", 32'h0);
      ld(3'd2, 32'h0000_2004, "dmem_kept_rst", 32'h1234_55EF); tick();
      ld(3'd2, 32'h0000_2008, "dmem_store_in_rst", 32'hCAFE_F00D); tick();

      // synchronizers: visible on the third cycle
      sw_i = 32'hA5A5_A5A5;
      ld(3'd2, 32'h0000_7800, "sw_sync_c1", 32'h0); tick();
      ld(3'd2, 32'h0000_7800, "sw_sync_c2", 32'h0); tick();
      ld(3'd2, 32'h0000_7800, "sw_sync_c3", 32'hA5A5_A5A5); tick();
      ld(3'd0, 32'h0000_7801, "lb_sw", 32'hFFFF_FFA5); tick();
      btn_i = 4'b1010;
      ld(3'd2, 32'h0000_7810, "btn_sync_c1", 32'h0); tick();
      ld(3'd2, 32'h0000_7810, "btn_sync_c2", 32'h0); tick();
      ld(3'd2, 32'h0000_7810, "btn_sync_c3", 32'h0000_000A); tick();

      // unmapped / read-only / disabled / illegal op
      st(3'd2, 32'h0000_5000, 32'hFFFF_FFFF);
      st(3'd2, 32'h0000_7800, 32'h0000_0000);
      ld(3'd2, 32'h0000_5000, "lw_unmapped", 32'h0); tick();
      ld(3'd2, 32'h0000_7800, "sw_reg_readonly", 32'hA5A5_A5A5); tick();
      acc(1'b0, 1'b0, 3'd2, 32'h0000_2004, 32'h0);
      push(K_LD, "rd_en_low", 32'h0); tick();
      ld(3'd3, 32'h0000_2004, "ld_op3", 32'h0); tick();
      ld(3'd6, 32'h0000_2004, "ld_op6", 32'h0); tick();
      st(3'd3, 32'h0000_2004, 32'h0000_0000);
      ld(3'd2, 32'h0000_2004, "st_op3_no_write", 32'h1234_55EF); tick();
      st(3'd2, 32'h0000_7000, 32'h0000_005A);
      st(3'd3, 32'h0000_7000, 32'h0000_00FF);
      push(K_LEDR, "st_op3_ledr_kept", 32'h0000_005A); tick();
      push(K_LEDR, "ledr_no_unmapped_alias", 32'h0000_005A);
      push(K_LEDG, "ledg_untouched", 32'h0);
      tick();

      tick();
      n_vec++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
